shift_unit_arbiter: RTL and testbench
=====================================

Name: shift_unit_arbiter

Overview:
- Shares one 32-bit shift/rotate datapath between NUM_REQ requesters.
- Arbitrates round-robin and accepts one operation at a time through a valid/ready handshake.
- Registers operands, computes the result, then holds it on a valid/ready response port tagged with the requester ID.
- Sits between the integer issue stage and the shifter datapath. It replaces per-unit shifter copies.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width. Fixed at 32 for this revision.
- SHAMT_W, 5, shift-amount width, equal to log2(DATA_W).
- ID_W, 2, requester-ID width, equal to clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  input  2*NUM_REQ  per-requester op: 0 shl, 1 rotl, 2 shr, 3 rotr.
- req_data  input  DATA_W*NUM_REQ  per-requester operand.
- req_shamt  input  SHAMT_W*NUM_REQ  per-requester shift amount.
- resp_valid  output  1  result valid.
- resp_ready  input  1  consumer accepts result.
- resp_id  output  ID_W  index of requester that owns the result.
- resp_data  output  DATA_W  shift/rotate result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - Synchronous, active-high, on clk rising edge.
  - State goes to IDLE; rr_ptr=0.
  - resp_valid=0, resp_id=0, resp_data=0, busy=0.
  - Operand registers cleared; req_ready=0 while rst is high.
  - Reset mid-operation discards any in-flight op; no response is produced.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g is the first index with req_valid set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g]=1 combinationally in IDLE only; all other bits are 0.
  - On the handshake (req_valid[g] & req_ready[g]) capture op, data, shamt and id=g, then go to EXEC.
  - No valid request: stay in IDLE.
- EXEC (1 cycle):
  - Datapath result is registered into resp_data and id into resp_id.
  - resp_valid is set to 1 and the FSM goes to RESP.
- RESP:
  - resp_valid, resp_data and resp_id are held stable until resp_ready=1.
  - On the response handshake: resp_valid=0, rr_ptr=(resp_id+1) mod NUM_REQ, go to IDLE.
  - req_ready stays 0 throughout EXEC and RESP.
- Latency:
  - Accept at edge N gives resp_valid=1 after edge N+1.
  - Minimum issue interval is 3 cycles (accept, exec, response handshake; IDLE on the next cycle).
- Datapath arithmetic, with k = shamt:
  - shl: data << k, zero fill.
  - shr: data >> k, logical, zero fill.
  - rotl: (data << k) | (data >> (32-k)).
  - rotr: (data >> k) | (data << (32-k)).
  - k=0 returns data unchanged for all four ops; there is no out-of-range slice.
  - k=31 is valid for all ops.
- Fairness:
  - rr_ptr advances only on completion, to one past the served requester.
  - A requester that withdraws req_valid before being granted is skipped without penalty.
- Simultaneous events:
  - All NUM_REQ valid in IDLE: the grant follows rr_ptr.
  - The response handshake and new requests in the same cycle do not overlap. The new grant is evaluated in the following IDLE cycle against the updated rr_ptr.
- Requester inputs are sampled only on the handshake edge. Later changes do not affect the in-flight op.
- busy=1 in EXEC and RESP.

Test Plan:
- Reset then idle: after rst released, all req_valid=0 for 10 cycles -> req_ready=0, resp_valid=0, busy=0, resp_data=0.
- Single op each type, requester 1:
  - data=0x8000_0001, shamt=4.
  - shl -> 0x0000_0010; rotl -> 0x0000_0018; shr -> 0x0800_0000; rotr -> 0x1800_0000.
  - Each has resp_id=1 and resp_valid one cycle after accept.
- Boundaries:
  - shamt=0 with rotl/rotr on 0xDEAD_BEEF -> 0xDEAD_BEEF.
  - shamt=31 rotl on 0x0000_0001 -> 0x8000_0000.
  - shamt=31 shr on 0x8000_0000 -> 0x0000_0001.
- Round-robin: all 4 requesters hold req_valid continuously with distinct ops, resp_ready=1 -> service order 0,1,2,3,0; each requester served once per 4 results.
- Backpressure: resp_ready=0 for 6 cycles after resp_valid -> resp_data/resp_id stable, req_ready=0 throughout; resp_ready=1 -> returns to IDLE next cycle and grants the next requester.
- Reset mid-op: assert rst during RESP with resp_valid=1 -> next cycle resp_valid=0, busy=0, rr_ptr=0; next grant goes to requester 0 if valid.

Source files
------------

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin shared 32-bit shift/rotate unit; ports req_* (per-requester valid/ready/op/data/shamt), resp_* (valid/ready/id/data), busy
module shift_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int ID_W    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [DATA_W*NUM_REQ-1:0]  req_data,
  input  logic [SHAMT_W*NUM_REQ-1:0] req_shamt,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, nxt;
  logic [ID_W-1:0] rr_ptr, gnt, idx, id_q;
  logic found, acc;
  logic [1:0] op_q;
  logic [DATA_W-1:0] data_q, res;
  logic [SHAMT_W-1:0] shamt_q;
  logic [2*DATA_W-1:0] rol, ror;
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign req_ready = (state == IDLE && found && !rst) ? NUM_REQ'(1) << gnt : '0;
  assign acc = |(req_valid & req_ready);
  assign busy = state != IDLE;
  always_comb begin
    nxt = state == IDLE ? (acc ? EXEC : IDLE) : state == EXEC ? RESP : (resp_ready ? IDLE : RESP);
  end
  always_comb begin
    rol = {data_q, data_q} << shamt_q;
    ror = {data_q, data_q} >> shamt_q;
    res = op_q == 2'd0 ? data_q << shamt_q :
          op_q == 2'd1 ? rol[2*DATA_W-1:DATA_W] :
          op_q == 2'd2 ? data_q >> shamt_q : ror[DATA_W-1:0];
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      op_q <= '0;
      data_q <= '0;
      shamt_q <= '0;
      id_q <= '0;
      resp_valid <= 1'b0;
      resp_id <= '0;
      resp_data <= '0;
    end else begin
      if (acc) begin
        op_q <= req_op[2*gnt +: 2];
        data_q <= req_data[DATA_W*gnt +: DATA_W];
        shamt_q <= req_shamt[SHAMT_W*gnt +: SHAMT_W];
        id_q <= gnt;
      end
      if (state == EXEC) begin
        resp_data <= res;
        resp_id <= id_q;
        resp_valid <= 1'b1;
      end
      if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        rr_ptr <= (resp_id == ID_W'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: directed and randomized checks of shift_unit_arbiter against a behavioural model
module tb_shift_unit_arbiter;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req_valid, req_ready;
  logic [2*N-1:0] req_op;
  logic [32*N-1:0] req_data;
  logic [5*N-1:0] req_shamt;
  logic resp_valid, resp_ready, busy;
  logic [1:0] resp_id;
  logic [31:0] resp_data;
  int tests = 0, fails = 0, ptr = 0;
  logic [N-1:0] v_mask;
  logic [1:0] v_op [N];
  logic [31:0] v_data [N];
  logic [4:0] v_sh [N];
  logic [31:0] spec_res [4];
  shift_unit_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .req_shamt(req_shamt),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] d, input int k);
    logic [31:0] r = d;
    if (op == 2'd0) return d << k;
    if (op == 2'd2) return d >> k;
    for (int i = 0; i < k; i++) r = op == 2'd1 ? {r[30:0], r[31]} : {r[0], r[31:1]};
    return r;
  endfunction
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
    return 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2] = v_op[i];
      req_data[32*i +: 32] = v_data[i];
      req_shamt[5*i +: 5] = v_sh[i];
    end
    req_valid = v_mask;
  endtask
  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      v_op[i] = 2'($urandom);
      v_data[i] = $urandom;
      v_sh[i] = 5'($urandom);
    end
  endtask
  task automatic one(input int r, input logic [1:0] op, input logic [31:0] d, input logic [4:0] k);
    v_mask = 4'(1 << r);
    v_op[r] = op;
    v_data[r] = d;
    v_sh[r] = k;
    apply();
    #1;
  endtask
  task automatic serve(input int hold, input bit use_want, input logic [31:0] want);
    int g;
    logic [31:0] e;
    g = pick(v_mask, ptr);
    e = use_want ? want : model(v_op[g], v_data[g], int'(v_sh[g]));
    chk("idle_busy", busy, 0);
    chk("idle_resp_valid", resp_valid, 0);
    chk("grant", req_ready, 32'(1) << g);
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    chk("exec_busy", busy, 1);
    chk("exec_resp_valid", resp_valid, 0);
    chk("exec_req_ready", req_ready, 0);
    scramble();
    apply();
    @(posedge clk); #1;
    chk("resp_valid", resp_valid, 1);
    chk("resp_id", resp_id, g);
    chk("resp_data", resp_data, e);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", resp_valid, 1);
      chk("hold_id", resp_id, g);
      chk("hold_data", resp_data, e);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    resp_ready = 1'b1;
    ptr = (g + 1) % N;
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
  initial begin
    spec_res = '{32'h0000_0010, 32'h0000_0018, 32'h0800_0000, 32'h1800_0000};
    v_mask = '0;
    for (int i = 0; i < N; i++) begin
      v_op[i] = '0;
      v_data[i] = '0;
      v_sh[i] = '0;
    end
    apply();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("idle_req_ready", req_ready, 0);
      chk("idle_valid", resp_valid, 0);
      chk("idle_busy0", busy, 0);
      chk("idle_data", resp_data, 0);
    end
    for (int o = 0; o < 4; o++) begin
      one(1, 2'(o), 32'h8000_0001, 5'd4);
      serve(0, 1'b1, spec_res[o]);
    end
    one(0, 2'd1, 32'hDEAD_BEEF, 5'd0);
    serve(0, 1'b1, 32'hDEAD_BEEF);
    one(0, 2'd3, 32'hDEAD_BEEF, 5'd0);
    serve(0, 1'b1, 32'hDEAD_BEEF);
    one(2, 2'd1, 32'h0000_0001, 5'd31);
    serve(0, 1'b1, 32'h8000_0000);
    one(3, 2'd2, 32'h8000_0000, 5'd31);
    serve(0, 1'b1, 32'h0000_0001);
    v_mask = 4'hF;
    for (int i = 0; i < N; i++) v_op[i] = 2'(i);
    apply();
    #1;
    for (int r = 0; r < 5; r++) begin
      chk("rr_order", 32'(pick(v_mask, ptr)), 32'(r % N));
      serve(0, 1'b0, 32'h0);
    end
    serve(6, 1'b0, 32'h0);
    serve(0, 1'b0, 32'h0);
    for (int r = 0; r < 40; r++) begin
      v_mask = 4'($urandom_range(1, 15));
      scramble();
      apply();
      #1;
      serve(int'($urandom_range(0, 3)), 1'b0, 32'h0);
    end
    v_mask = 4'b0100;
    apply();
    #1;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midop_resp_valid", resp_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midop_rst_valid", resp_valid, 0);
    chk("midop_rst_busy", busy, 0);
    chk("midop_rst_req_ready", req_ready, 0);
    chk("midop_rst_data", resp_data, 0);
    rst = 1'b0;
    resp_ready = 1'b1;
    ptr = 0;
    v_mask = 4'hF;
    apply();
    #1;
    serve(0, 1'b0, 32'h0);
    v_mask = '0;
    apply();
    @(posedge clk); #1;
    chk("final_idle_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
